// File: rtl/dct8_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between row-pass and column-pass DCT stages.
// Latency: column 0 is registered one edge after the row-7 write; then 1 column/cycle.
// Backpressure: in_ready = !full[wr_bank]; output holds stable while valid_out && !out_ready.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   valid_in, data_in    one row per handshake (data_in[c] = column c), in_ready qualifies
//   valid_out, out_ready column handshake to the column DCT
//   data_out             column vector (data_out[r] = row r)
//   out_col, out_last    column index of data_out, high on column 7
module dct8_transpose_buf #(
    parameter int DATA_W = 16,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in [N-1:0],
    output logic              in_ready,
    output logic              valid_out,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out [N-1:0],
    output logic [2:0]        out_col,
    output logic              out_last
);

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    // Two banks of N x N words, indexed [bank][row][col]. Not cleared by reset:
    // the full flags alone decide whether a bank's contents are meaningful.
    logic [DATA_W-1:0] mem [2][N][N];

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_bank;
    logic [2:0] wr_row;
    logic       rd_bank;
    logic [2:0] rd_col;

    logic wr_en;
    logic rd_en;

    // in_ready depends on registered state only.
    assign in_ready = !full[wr_bank];
    assign wr_en    = valid_in && in_ready;
    // Load the output register when a full bank is waiting and the register
    // is either empty or being emptied by a transfer this cycle.
    assign rd_en    = full[rd_bank] && (!valid_out || out_ready);

    // A write needs !full and a read needs full, so when both complete a block
    // in the same cycle they necessarily touch different banks.
    always_comb begin
        full_nxt = full;
        if (wr_en && (wr_row == LAST_IDX)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_en && (rd_col == LAST_IDX)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Bank storage write port.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_bank][wr_row][c] <= data_in[c];
            end
        end
    end

    // Pointers and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_bank <= 1'b0;
            rd_col  <= 3'd0;
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                if (wr_row == LAST_IDX) begin
                    wr_bank <= !wr_bank;
                    wr_row  <= 3'd0;
                end else begin
                    wr_row  <= wr_row + 3'd1;
                end
            end
            if (rd_en) begin
                if (rd_col == LAST_IDX) begin
                    rd_bank <= !rd_bank;
                    rd_col  <= 3'd0;
                end else begin
                    rd_col  <= rd_col + 3'd1;
                end
            end
        end
    end

    // Output register: reads one column of the draining bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            out_col   <= 3'd0;
            out_last  <= 1'b0;
            for (int r = 0; r < N; r++) begin
                data_out[r] <= '0;
            end
        end else if (rd_en) begin
            valid_out <= 1'b1;
            out_col   <= rd_col;
            out_last  <= (rd_col == LAST_IDX);
            for (int r = 0; r < N; r++) begin
                data_out[r] <= mem[rd_bank][r][rd_col];
            end
        end else if (valid_out && out_ready) begin
            // Last column accepted with nothing queued: drop valid, keep data.
            valid_out <= 1'b0;
        end
    end

endmodule
